// File: rtl/dbus_mem_responder.sv
// Memory-side data-bus responder: one request at a time, fixed-latency single-cycle response, word RAM.
// dreq = {valid, addr[31:0], size[2:0], strobe[7:0], data[63:0]}; dresp = {addr_ok, data_ok, data[63:0]}.
// Optional random stall insertion is enabled by defining DBUS_RESP_RANDOM_STALL_EN.
module dbus_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [107:0] dreq,
  output logic [65:0]  dresp
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 3) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d, wait_total;
  logic               do_resp, capture;

  logic               req_valid;
  logic [31:0]        req_addr;
  logic [2:0]         req_size;
  logic [7:0]         req_strobe;
  logic [63:0]        req_data;
  logic [IDX_W-1:0]   req_idx;

  logic [IDX_W-1:0]   idx_q;
  logic [2:0]         size_q;
  logic [7:0]         strobe_q;
  logic [63:0]        wdata_q;

  logic [IDX_W-1:0]   sel_idx;
  logic [7:0]         sel_strobe;
  logic [63:0]        sel_data;
  logic [63:0]        merged;

  logic               resp_ok;
  logic [63:0]        resp_data;
  logic [1:0]         extra;
  logic               unused_bits;

  logic [63:0]        mem [DEPTH];

  assign {req_valid, req_addr, req_size, req_strobe, req_data} = dreq;
  assign req_idx = req_addr[IDX_W+2:3];

`ifdef DBUS_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign extra       = lfsr[1:0];
  assign unused_bits = ^{req_addr, size_q};
`else
  assign extra       = 2'b00;
  assign unused_bits = ^{req_addr, size_q, LFSR_SEED};
`endif

  // Number of WAIT cycles for a request accepted now; zero means straight to RESP.
  assign wait_total = CNT_W'(LATENCY - 1) + CNT_W'(extra);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    do_resp = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          if (wait_total == '0) begin
            state_d = RESP;
            do_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = wait_total - CNT_W'(1);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_d = RESP;
          do_resp = 1'b1;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A zero-wait response is produced on the acceptance edge, so it must use the live request.
  always_comb begin
    if (state == IDLE) begin
      sel_idx    = req_idx;
      sel_strobe = req_strobe;
      sel_data   = req_data;
    end else begin
      sel_idx    = idx_q;
      sel_strobe = strobe_q;
      sel_data   = wdata_q;
    end
  end

  always_comb begin
    merged = mem[sel_idx];
    for (int unsigned i = 0; i < 8; i++) begin
      if (sel_strobe[i]) merged[8*i +: 8] = sel_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      resp_ok   <= 1'b0;
      resp_data <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      resp_ok   <= do_resp;
      resp_data <= do_resp ? merged : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      idx_q    <= req_idx;
      size_q   <= req_size;
      strobe_q <= req_strobe;
      wdata_q  <= req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_resp && (sel_strobe != '0)) mem[sel_idx] <= merged;
  end

  assign dresp = {resp_ok, resp_ok, resp_data};

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Self-checking bench for dbus_mem_responder: directed table, reset corner cases, random traffic vs a byte-level memory model.
module tb_dbus_mem_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 2;

  logic         clk  = 1'b0;
  logic         rst  = 1'b0;
  logic [107:0] dreq = '0;
  logic [65:0]  dresp;

  int n_cmp = 0;
  int n_bad = 0;

  dbus_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .LFSR_SEED(16'hACE1)) dut (
    .clk  (clk),
    .rst  (rst),
    .dreq (dreq),
    .dresp(dresp)
  );

  always #5 clk = ~clk;

  logic [7:0] ref_byte [DEPTH][8];
  bit         ref_bk   [DEPTH][8];
  int         lat_run  [2][8];

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  function automatic int unsigned ref_index(input logic [31:0] a);
    return (int'(a) / 8) % DEPTH;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic txn(input string name, input logic [31:0] addr, input logic [7:0] strobe,
                     input logic [63:0] wdata, output logic [63:0] rdata, output int lat);
    dreq = {1'b1, addr, 3'd3, strobe, wdata};
    @(posedge clk); #1;
    dreq = '0;
    lat  = 1;
    while (dresp[64] !== 1'b1 && lat <= 16) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = dresp[63:0];
    if (dresp[64] !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: no data_ok after %0d edges, required within %0d", name, lat, LATENCY + 3);
    end else begin
      check({name, " addr_ok"}, {63'd0, dresp[65]}, 64'd1);
    end
    @(posedge clk); #1;
    check({name, " ok_drop"}, {62'd0, dresp[65:64]}, 64'd0);
    check({name, " data_drop"}, dresp[63:0], 64'd0);
  endtask

  task automatic tx_and_check(input string name, input logic [31:0] addr, input logic [7:0] strobe,
                              input logic [63:0] wdata, output logic [63:0] rd, output int lat);
    logic [63:0] exp, mask;
    int unsigned idx;
    idx  = ref_index(addr);
    exp  = '0;
    mask = '0;
    for (int b = 0; b < 8; b++) begin
      if (strobe[b]) begin
        exp[8*b +: 8]  = wdata[8*b +: 8];
        mask[8*b +: 8] = 8'hFF;
      end else if (ref_bk[idx][b]) begin
        exp[8*b +: 8]  = ref_byte[idx][b];
        mask[8*b +: 8] = 8'hFF;
      end
    end
    txn(name, addr, strobe, wdata, rd, lat);
`ifdef DBUS_RESP_RANDOM_STALL_EN
    n_cmp++;
    if (lat < int'(LATENCY) || lat > int'(LATENCY) + 3) begin
      n_bad++;
      $display("FAIL %s latency: got %0d expected %0d..%0d", name, lat, LATENCY, LATENCY + 3);
    end
`else
    check({name, " latency"}, 64'(lat), 64'(LATENCY));
`endif
    if (mask != '0) check({name, " model"}, rd & mask, exp);
    for (int b = 0; b < 8; b++) begin
      if (strobe[b]) begin
        ref_byte[idx][b] = wdata[8*b +: 8];
        ref_bk[idx][b]   = 1'b1;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    vec_t        vecs [8];
    logic [63:0] rd;
    int          lat;

    vecs[0] = '{"wr_full",    32'h0000_0040, 8'hFF, 64'h1122334455667788, 64'h1122334455667788};
    vecs[1] = '{"rd_full",    32'h0000_0040, 8'h00, 64'h0,                64'h1122334455667788};
    vecs[2] = '{"wr_partial", 32'h0000_0040, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 64'h11223344AAAAAAAA};
    vecs[3] = '{"rd_partial", 32'h0000_0043, 8'h00, 64'h0,                64'h11223344AAAAAAAA};
    vecs[4] = '{"wr_wrap",    32'h0000_2040, 8'hFF, 64'h5,                64'h5};
    vecs[5] = '{"rd_wrap",    32'h0000_0040, 8'h00, 64'h0,                64'h5};
    vecs[6] = '{"wr_80_zero", 32'h0000_0080, 8'hFF, 64'h0,                64'h0};
    vecs[7] = '{"wr_hi_byte", 32'h0000_0088, 8'h80, 64'hFF00000000000000, 64'hFF00000000000000};

    // Reset held with a valid request present: nothing may respond.
    rst  = 1'b0;
    dreq = {1'b1, 32'h40, 3'd3, 8'hFF, 64'hDEADBEEFCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst_ok_%0d", i), {62'd0, dresp[65:64]}, 64'd0);
      check($sformatf("rst_data_%0d", i), dresp[63:0], 64'd0);
    end
    dreq = '0;
    rst  = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", {62'd0, dresp[65:64]}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      tx_and_check(vecs[i].name, vecs[i].addr, vecs[i].strobe, vecs[i].data, rd, lat);
      check({vecs[i].name, " data"}, rd, vecs[i].exp);
    end

    // Reset lands on the edge that would enter RESP for a write to 0x80: write must be dropped.
    dreq = {1'b1, 32'h80, 3'd3, 8'hFF, 64'hDEADBEEF12345678};
    @(posedge clk); #1;
    dreq = '0;
    rst  = 1'b0;
    @(posedge clk); #1;
    check("rst_resp_ok", {62'd0, dresp[65:64]}, 64'd0);
    @(posedge clk); #1;
    check("rst_resp_ok2", {62'd0, dresp[65:64]}, 64'd0);
    check("rst_resp_data", dresp[63:0], 64'd0);
    rst = 1'b1;
    tx_and_check("rd_80_after_rst", 32'h80, 8'h00, 64'h0, rd, lat);
    check("rd_80_after_rst data", rd, 64'h0);

    // Random traffic on 16 words, random upper/lower address bits to exercise wrap and ignored bits.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [7:0]  s;
      logic [63:0] d;
      a = ($urandom << 13) | (32'($urandom_range(0, 15)) << 3) | ($urandom & 32'h7);
      s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      d = {$urandom, $urandom};
      tx_and_check($sformatf("rand_%0d", i), a, s, d, rd, lat);
    end

    // Two identical post-reset runs of 8 back-to-back reads must see identical latencies.
    for (int r = 0; r < 2; r++) begin
      do_reset(2);
      for (int i = 0; i < 8; i++) begin
        tx_and_check($sformatf("b2b_r%0d_%0d", r, i), 32'(32'h40 + 8 * i), 8'h00, 64'h0, rd, lat);
        lat_run[r][i] = lat;
      end
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lat_repeat_%0d", i), 64'(lat_run[1][i]), 64'(lat_run[0][i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
